// File: rtl/dc_miss_ctrl.sv
// Data-cache miss sequencer: optional dirty-victim write-back, line refill,
// tag update, then the two-pulse completion handshake back to MA/WB.
module dc_miss_ctrl #(
  parameter int DWIDTH = 11,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 miss_req,
  input  logic [31:4]          miss_line_adr,
  input  logic                 victim_dirty,
  input  logic [31:4]          victim_line_adr,
  output logic [DWIDTH-3:0]    ram_radr_all,
  output logic                 ram_ren_all,
  input  logic [127:0]         ram_rdata_all,
  output logic [DWIDTH-3:0]    ram_wadr_all,
  output logic [127:0]         ram_wdata_all,
  output logic                 ram_wen_all,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:4]          mem_adr,
  output logic [127:0]         mem_wdata,
  input  logic                 mem_ack,
  input  logic [127:0]         mem_rdata,
  output logic                 tag_we,
  output logic [DWIDTH-3:0]    tag_idx,
  output logic [31:DWIDTH+2]   tag_wtag,
  output logic                 dc_stall,
  output logic                 dc_stall_fin,
  output logic                 dc_stall_fin2,
  output logic                 busy,
  output logic [CNT_W-1:0]     perf_miss_cnt,
  output logic [CNT_W-1:0]     perf_wb_cnt
);

  typedef enum logic [2:0] {
    IDLE, WB_RD, WB_CAP, WB_REQ, FILL_REQ, FILL_WR, FIN1, FIN2
  } state_t;

  state_t       state_reg;
  logic [31:4]  miss_adr_reg;
  logic [31:4]  victim_adr_reg;
  logic [127:0] wb_buf_reg;
  logic [127:0] fill_buf_reg;
  logic [1:0]   cnt_inc;

  // Index/data outputs are don't-care outside their strobes, so they come
  // straight from the latched registers.
  assign ram_radr_all  = victim_adr_reg[DWIDTH+1:4];
  assign ram_wadr_all  = miss_adr_reg[DWIDTH+1:4];
  assign ram_wdata_all = fill_buf_reg;
  assign mem_wdata     = wb_buf_reg;
  assign tag_idx       = miss_adr_reg[DWIDTH+1:4];
  assign tag_wtag      = miss_adr_reg[31:DWIDTH+2];

  assign busy     = (state_reg != IDLE);
  assign dc_stall = ~rst_n & (miss_req | (state_reg != IDLE));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg      <= IDLE;
      miss_adr_reg   <= '0;
      victim_adr_reg <= '0;
      wb_buf_reg     <= '0;
      fill_buf_reg   <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_adr        <= '0;
      ram_ren_all    <= 1'b0;
      ram_wen_all    <= 1'b0;
      tag_we         <= 1'b0;
      dc_stall_fin   <= 1'b0;
      dc_stall_fin2  <= 1'b0;
    end else begin
      // Strobes are registered decodes of the state being entered.
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      ram_ren_all   <= 1'b0;
      ram_wen_all   <= 1'b0;
      tag_we        <= 1'b0;
      dc_stall_fin  <= 1'b0;
      dc_stall_fin2 <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (miss_req) begin
            miss_adr_reg   <= miss_line_adr;
            victim_adr_reg <= victim_line_adr;
            if (victim_dirty) begin
              state_reg   <= WB_RD;
              ram_ren_all <= 1'b1;
            end else begin
              state_reg <= FILL_REQ;
              mem_req   <= 1'b1;
              mem_adr   <= miss_line_adr;
            end
          end
        end
        WB_RD: state_reg <= WB_CAP;
        WB_CAP: begin
          wb_buf_reg <= ram_rdata_all;
          mem_req    <= 1'b1;
          mem_we     <= 1'b1;
          mem_adr    <= victim_adr_reg;
          state_reg  <= WB_REQ;
        end
        WB_REQ: begin
          mem_req <= 1'b1;
          if (mem_ack) begin
            mem_adr   <= miss_adr_reg;
            state_reg <= FILL_REQ;
          end else begin
            mem_we <= 1'b1;
          end
        end
        FILL_REQ: begin
          if (mem_ack) begin
            fill_buf_reg <= mem_rdata;
            ram_wen_all  <= 1'b1;
            tag_we       <= 1'b1;
            state_reg    <= FILL_WR;
          end else begin
            mem_req <= 1'b1;
          end
        end
        FILL_WR: begin
          dc_stall_fin <= 1'b1;
          state_reg    <= FIN1;
        end
        FIN1: begin
          dc_stall_fin2 <= 1'b1;
          state_reg     <= FIN2;
        end
        FIN2:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cnt_inc[0] = (state_reg == IDLE) && miss_req;
  assign cnt_inc[1] = (state_reg == WB_CAP);

  // Saturating counters: 0 = accepted misses, 1 = write-backs.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
          cnt_reg <= '0;
        else if (cnt_inc[gi] && !(&cnt_reg))
          cnt_reg <= cnt_reg + 1'b1;
      end
    end
  endgenerate

  assign perf_miss_cnt = g_cnt[0].cnt_reg;
  assign perf_wb_cnt   = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_dc_miss_ctrl.sv
// Directed bench for dc_miss_ctrl: behavioural line RAM and memory responder,
// per-miss event logs, hand-computed expectations.
module tb_dc_miss_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         miss_req = 1'b0;
  logic [27:0]  miss_line_adr = '0;
  logic         victim_dirty = 1'b0;
  logic [27:0]  victim_line_adr = '0;
  logic [8:0]   ram_radr_all;
  logic         ram_ren_all;
  logic [127:0] ram_rdata_all = '0;
  logic [8:0]   ram_wadr_all;
  logic [127:0] ram_wdata_all;
  logic         ram_wen_all;
  logic         mem_req;
  logic         mem_we;
  logic [27:0]  mem_adr;
  logic [127:0] mem_wdata;
  logic         mem_ack = 1'b0;
  logic [127:0] mem_rdata = '0;
  logic         tag_we;
  logic [8:0]   tag_idx;
  logic [18:0]  tag_wtag;
  logic         dc_stall, dc_stall_fin, dc_stall_fin2, busy;
  logic [15:0]  perf_miss_cnt, perf_wb_cnt;

  // Narrow-counter twin sharing every input, used for the saturation check.
  logic [8:0]   s_radr, s_wadr, s_tidx;
  logic         s_ren, s_wen, s_req, s_we, s_twe, s_stall, s_fin, s_fin2, s_busy;
  logic [127:0] s_wdata, s_mwdata;
  logic [27:0]  s_madr;
  logic [18:0]  s_wtag;
  logic [2:0]   s_miss_cnt, s_wb_cnt;

  dc_miss_ctrl #(.DWIDTH(11), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_line_adr(miss_line_adr),
    .victim_dirty(victim_dirty), .victim_line_adr(victim_line_adr),
    .ram_radr_all(ram_radr_all), .ram_ren_all(ram_ren_all), .ram_rdata_all(ram_rdata_all),
    .ram_wadr_all(ram_wadr_all), .ram_wdata_all(ram_wdata_all), .ram_wen_all(ram_wen_all),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .tag_we(tag_we), .tag_idx(tag_idx),
    .tag_wtag(tag_wtag), .dc_stall(dc_stall), .dc_stall_fin(dc_stall_fin),
    .dc_stall_fin2(dc_stall_fin2), .busy(busy), .perf_miss_cnt(perf_miss_cnt),
    .perf_wb_cnt(perf_wb_cnt)
  );

  dc_miss_ctrl #(.DWIDTH(11), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_line_adr(miss_line_adr),
    .victim_dirty(victim_dirty), .victim_line_adr(victim_line_adr),
    .ram_radr_all(s_radr), .ram_ren_all(s_ren), .ram_rdata_all(ram_rdata_all),
    .ram_wadr_all(s_wadr), .ram_wdata_all(s_wdata), .ram_wen_all(s_wen),
    .mem_req(s_req), .mem_we(s_we), .mem_adr(s_madr), .mem_wdata(s_mwdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .tag_we(s_twe), .tag_idx(s_tidx),
    .tag_wtag(s_wtag), .dc_stall(s_stall), .dc_stall_fin(s_fin),
    .dc_stall_fin2(s_fin2), .busy(s_busy), .perf_miss_cnt(s_miss_cnt),
    .perf_wb_cnt(s_wb_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Responder controls and per-miss logs
  logic [127:0] ram_model [512];
  int           ack_delay = 0;
  logic [127:0] fill_data = '0;
  int           spur = 0;
  int           wait_cnt = 0;
  logic         rd_pend = 1'b0;
  logic [8:0]   rd_adr = '0;
  logic         req_prev = 1'b0, ack_prev = 1'b0, we_prev = 1'b0;
  logic [27:0]  adr_prev = '0;
  logic [127:0] wd_prev = '0;

  int cyc = 0, stall_n = 0, fin_n = 0, fin2_n = 0, fin_cyc = 0, fin2_cyc = 0;
  int wen_n = 0, tag_n = 0, ren_n = 0, accept_n = 0;
  logic [8:0]   wen_adr = '0, tag_i = '0, ren_adr = '0;
  logic [127:0] wen_data = '0;
  logic [18:0]  tag_t = '0;
  logic         txn_we [$];
  logic [27:0]  txn_adr [$];
  logic [127:0] txn_data [$];

  task automatic clear_logs();
    stall_n = 0; fin_n = 0; fin2_n = 0; wen_n = 0; tag_n = 0; ren_n = 0; accept_n = 0;
    txn_we.delete(); txn_adr.delete(); txn_data.delete();
  endtask

  // Drive responses on the falling edge, sample outputs 1 time unit later.
  initial begin
    for (int i = 0; i < 512; i++) ram_model[i] = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      ram_rdata_all = rd_pend ? ram_model[rd_adr] : '0;
      rd_pend = ram_ren_all;
      rd_adr  = ram_radr_all;
      if (mem_req) begin
        if (req_prev && !ack_prev) begin
          check_val("mem_adr_hold", mem_adr, adr_prev);
          check_val("mem_we_hold", mem_we, we_prev);
          if (mem_we) check_val("mem_wdata_hold", mem_wdata, wd_prev);
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = fill_data;
          txn_we.push_back(mem_we);
          txn_adr.push_back(mem_adr);
          txn_data.push_back(mem_wdata);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spur != 0) mem_ack = 1'b1;
      end
      req_prev = mem_req; ack_prev = mem_ack; adr_prev = mem_adr;
      we_prev = mem_we; wd_prev = mem_wdata;
      if (ram_wen_all) begin
        ram_model[ram_wadr_all] = ram_wdata_all;
        wen_n++; wen_adr = ram_wadr_all; wen_data = ram_wdata_all;
      end
      if (tag_we) begin
        tag_n++; tag_i = tag_idx; tag_t = tag_wtag;
      end
      #1;
      cyc++;
      if (dc_stall) stall_n++;
      if (dc_stall_fin) begin fin_n++; fin_cyc = cyc; end
      if (dc_stall_fin2) begin fin2_n++; fin2_cyc = cyc; end
      if (ram_ren_all) begin ren_n++; ren_adr = ram_radr_all; end
      if (!busy && miss_req) accept_n++;
    end
  end

  task automatic wait_fin2(input string tag);
    int n = 0;
    while (fin2_n == 0 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check_val({tag, "_done"}, (fin2_n != 0), 1'b1);
  endtask

  task automatic run_miss(input string tag, input logic [27:0] line, input logic dirty,
                          input logic [27:0] vadr, input int dly, input logic [127:0] rdata);
    @(negedge clk);
    clear_logs();
    miss_line_adr = line; victim_dirty = dirty; victim_line_adr = vadr;
    ack_delay = dly; fill_data = rdata; miss_req = 1'b1;
    @(negedge clk);
    miss_req = 1'b0;
    wait_fin2(tag);
    @(negedge clk); #2;
    check_val({tag, "_idle_after"}, {busy, dc_stall}, 2'b00);
  endtask

  localparam logic [127:0] PAT_A5  = {16{8'hA5}};
  localparam logic [127:0] PAT_PRE = {2{64'h0123456789ABCDEF}};
  localparam logic [127:0] PAT_B   = {4{32'hDEADBEEF}};
  localparam logic [127:0] PAT_C   = {8{16'h5A3C}};

  initial begin
    // Reset state
    @(negedge clk); #2;
    check_val("rst_outputs", {mem_req, mem_we, ram_ren_all, ram_wen_all, tag_we,
                              dc_stall, dc_stall_fin, dc_stall_fin2, busy}, 9'd0);
    check_val("rst_counters", {perf_miss_cnt, perf_wb_cnt}, 32'd0);
    check_val("rst_mem_adr", mem_adr, 28'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // Clean miss, ack 3 cycles after the request
    run_miss("clean", 28'h0000123, 1'b0, 28'h0000123, 3, PAT_A5);
    check_val("clean_stall", stall_n, 8);
    check_val("clean_txn_n", txn_we.size(), 1);
    check_val("clean_txn", {txn_we[0], txn_adr[0]}, {1'b0, 28'h0000123});
    check_val("clean_wen", {wen_n[3:0], wen_adr}, {4'd1, 9'h123});
    check_val("clean_wdata", wen_data, PAT_A5);
    check_val("clean_tag", {tag_n[3:0], tag_i, tag_t}, {4'd1, 9'h123, 19'd0});
    check_val("clean_fin", {fin_n[3:0], fin2_n[3:0]}, {4'd1, 4'd1});
    check_val("clean_fin_gap", fin2_cyc - fin_cyc, 1);
    check_val("clean_cnt", {perf_miss_cnt, perf_wb_cnt}, {16'd1, 16'd0});
    check_val("clean_no_ren", ren_n, 0);

    // Dirty miss: write back the preloaded victim, then refill
    ram_model[9'h123] = PAT_PRE;
    run_miss("dirty", 28'h0000123, 1'b1, 28'h0080123, 2, PAT_B);
    check_val("dirty_ren", {ren_n[3:0], ren_adr}, {4'd1, 9'h123});
    check_val("dirty_txn_n", txn_we.size(), 2);
    check_val("dirty_wb", {txn_we[0], txn_adr[0]}, {1'b1, 28'h0080123});
    check_val("dirty_wb_data", txn_data[0], PAT_PRE);
    check_val("dirty_fill", {txn_we[1], txn_adr[1]}, {1'b0, 28'h0000123});
    check_val("dirty_ram", ram_model[9'h123], PAT_B);
    check_val("dirty_stall", stall_n, 12);
    check_val("dirty_cnt", {perf_miss_cnt, perf_wb_cnt}, {16'd2, 16'd1});

    // Zero-wait acks on the dirty path
    run_miss("zw", 28'h1234567, 1'b1, 28'h0ABC167, 0, PAT_C);
    check_val("zw_stall", stall_n, 8);
    check_val("zw_txn_n", txn_we.size(), 2);
    check_val("zw_txn_we", {txn_we[0], txn_we[1]}, 2'b10);
    check_val("zw_adr", {txn_adr[0], txn_adr[1]}, {28'h0ABC167, 28'h1234567});
    check_val("zw_tag", {tag_i, tag_t}, {9'h167, 19'h091A2});
    check_val("zw_wen", {wen_n[3:0], wen_adr, ram_model[9'h167]}, {4'd1, 9'h167, PAT_C});
    check_val("zw_cnt", {perf_miss_cnt, perf_wb_cnt}, {16'd3, 16'd2});

    // Ack while no request is outstanding is ignored
    @(negedge clk); #2;
    clear_logs();
    spur = 1;
    repeat (3) @(negedge clk);
    #2;
    spur = 0;
    @(negedge clk); #2;
    check_val("spur_ack", {busy, wen_n[3:0], tag_n[3:0]}, 9'd0);

    // miss_req held high through the whole sequence
    @(negedge clk);
    clear_logs();
    miss_line_adr = 28'h0000200; victim_dirty = 1'b0; ack_delay = 0;
    fill_data = PAT_A5; miss_req = 1'b1;
    wait_fin2("held1");
    check_val("held_one_accept", accept_n, 1);
    check_val("held_stall1", stall_n, 5);
    @(negedge clk); #2;
    check_val("held_reaccept", accept_n, 2);
    check_val("held_txn_before", txn_we.size(), 1);
    @(negedge clk);
    miss_req = 1'b0;
    fin2_n = 0;
    wait_fin2("held2");
    check_val("held_txn_after", txn_we.size(), 2);
    check_val("held_cnt", perf_miss_cnt, 16'd5);

    // Reset while the write-back request is outstanding
    @(negedge clk);
    clear_logs();
    miss_line_adr = 28'h0000300; victim_dirty = 1'b1; victim_line_adr = 28'h0F00300;
    ack_delay = 50; miss_req = 1'b1;
    @(negedge clk);
    miss_req = 1'b0;
    begin
      int n = 0;
      while (!(mem_req && mem_we) && n < 20) begin
        @(negedge clk); #2;
        n++;
      end
      check_val("rst_wbreq_seen", {mem_req, mem_we}, 2'b11);
    end
    rst_n = 1'b1;
    #1;
    check_val("rst_async", {mem_req, mem_we, dc_stall, busy}, 4'd0);
    check_val("rst_async_cnt", {perf_miss_cnt, perf_wb_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    check_val("rst_no_write", {wen_n[3:0], tag_n[3:0], txn_we.size() > 0}, 9'd0);
    run_miss("post_rst", 28'h0000300, 1'b0, 28'h0000300, 0, PAT_B);
    check_val("post_rst_stall", stall_n, 5);
    check_val("post_rst_wen", {wen_n[3:0], wen_adr}, {4'd1, 9'h100});
    check_val("post_rst_cnt", {perf_miss_cnt, perf_wb_cnt}, {16'd1, 16'd0});

    // Saturation: the 3-bit twin must stop at 7
    for (int k = 0; k < 9; k++)
      run_miss("sat", 28'h0000010 + 28'(k), 1'b0, 28'h0, 0, PAT_C);
    check_val("sat_wide", perf_miss_cnt, 16'd10);
    check_val("sat_narrow", s_miss_cnt, 3'd7);
    check_val("sat_narrow_wb", s_wb_cnt, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
